// File: rtl/usrt_tx_if.sv
// usrt_tx_if: producer byte handshake plus serial line and status of usrt_tx.
//   Tx_Byte  [7:0] byte offered by the producer
//   Tx_Valid       producer has a byte on Tx_Byte
//   Tx_Ready       transmitter holding buffer is empty
//   SO             serial data out, idle high
//   Busy           a frame is on SO
//   Tx_Done        one-cycle pulse after each frame's last stop cycle
interface usrt_tx_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] Tx_Byte;
  logic              Tx_Valid;
  logic              Tx_Ready;
  logic              SO;
  logic              Busy;
  logic              Tx_Done;

  modport master (
    output Tx_Byte, Tx_Valid,
    input  Tx_Ready, SO, Busy, Tx_Done
  );

  modport slave (
    input  Tx_Byte, Tx_Valid,
    output Tx_Ready, SO, Busy, Tx_Done
  );
endinterface

// File: rtl/usrt_tx.sv
// usrt_tx: synchronous serial transmitter, one bit per CLK cycle.
// Frame: 1 start cycle (low), 8 data cycles LSB first, STOP_BITS stop
// cycles (high). A one-entry holding buffer lets the next byte be
// accepted while a frame is on the line, so frames stream back-to-back.
// Ports:
//   CLK        sole clock, rising edge
//   RST        asynchronous active-high reset
//   bus.slave  Tx_Byte/Tx_Valid in; Tx_Ready (combinational),
//              SO, Busy, Tx_Done (registered) out
module usrt_tx #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic     CLK,
  input  logic     RST,
  usrt_tx_if.slave bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [0:0]       STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("usrt_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_stop_cnt;
  logic              r_so;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_last_stop;
  logic              w_load;

  // Accept only into an empty buffer; the edge that drains it cannot refill it.
  assign w_accept    = bus.Tx_Valid & ~r_buf_full;
  assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == STOP_LAST);
  // Buffer drains into the shifter when a frame starts, from IDLE or back-to-back.
  assign w_load      = r_buf_full && ((r_state == S_IDLE) || w_last_stop);

  // One-entry holding buffer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf      <= bus.Tx_Byte;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end
  end

  // Frame sequencer with registered line/status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_stop_cnt <= 1'b0;
      r_so       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_so <= 1'b1;
          if (w_load) begin
            r_shift <= r_buf;
            r_state <= S_START;
            r_so    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          // bit 0 goes out next; the shifter then holds bit 1 at its LSB
          r_so    <= r_shift[0];
          r_shift <= {1'b0, r_shift[DATA_W-1:1]};
          r_idx   <= '0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          if (r_idx == IDX_LAST) begin
            r_so       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_so    <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_W-1:1]};
            r_idx   <= r_idx + 1'b1;
          end
        end
        S_STOP: begin
          if (w_last_stop) begin
            r_done <= 1'b1;
            r_idx  <= '0;
            if (r_buf_full) begin
              r_shift <= r_buf;
              r_state <= S_START;
              r_so    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_so    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_so    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Tx_Ready = ~r_buf_full;
  assign bus.SO       = r_so;
  assign bus.Busy     = r_busy;
  assign bus.Tx_Done  = r_done;

endmodule

// File: doc/usrt_tx.md
USRT_TX -- requirements
Module: usrt_tx

Interface
REQ-001 SHALL provide parameter STOP_BITS, default 1, number of stop-bit cycles per frame; legal values 1 or 2.
REQ-002 SHALL provide port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port Tx_Byte  input  8  byte to transmit, sampled on accept.
REQ-005 SHALL provide port Tx_Valid  input  1  producer has a byte on Tx_Byte.
REQ-006 SHALL provide port Tx_Ready  output  1  holding buffer empty, byte can be accepted.
REQ-007 SHALL provide port SO  output  1  registered serial data out, idle high, feeds receiver SI.
REQ-008 SHALL provide port Busy  output  1  high while a frame is on SO (START, DATA or STOP state).
REQ-009 SHALL provide port Tx_Done  output  1  one-cycle pulse at the end of each frame's last stop cycle.

Function
REQ-010 SHALL accept a byte on a rising edge where Tx_Valid=1 and Tx_Ready=1, storing it in a one-entry holding buffer.
REQ-011 SHALL drive Tx_Ready = not(buffer full), combinationally; no accept while the buffer is full, even on the edge that empties it.
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 IDLE: SO=1; on an edge with the buffer full, move buffer to shift register, clear buffer, go to START, drive SO=0.
REQ-014 START: lasts exactly 1 cycle with SO=0; then go to DATA, SO=bit 0.
REQ-015 DATA: 8 cycles, bits 0..7 LSB first, one bit per cycle, 3-bit index 0..7; after bit 7 go to STOP, SO=1.
REQ-016 STOP: SO=1 for STOP_BITS cycles; Tx_Done pulses high on the edge leaving STOP.
REQ-017 SHALL, on leaving STOP with the buffer full, go directly to START (back-to-back, no idle cycle); otherwise go to IDLE.
REQ-018 Frame length SHALL be 1+8+STOP_BITS cycles; with STOP_BITS=1 continuous streaming SHALL give one byte per 10 cycles.
REQ-019 Latency: byte accepted on edge e SHALL, when IDLE, produce SO=0 in the cycle after edge e+1.
REQ-020 SHALL hold the shift register stable against Tx_Byte changes after accept; a new accept during a frame SHALL fill only the buffer.
REQ-021 Busy SHALL be 1 exactly in START, DATA and STOP states.
REQ-022 SO, Busy and Tx_Done SHALL be registered outputs (no combinational path from inputs).
REQ-023 Framing SHALL match the sibling receiver: start low 1 cycle, data sampled on the following 8 edges, at least one high cycle before the next start.

Reset
REQ-024 RST=1 SHALL immediately force state IDLE, SO=1, Busy=0, Tx_Done=0, buffer empty (Tx_Ready=1), bit index 0, independent of CLK.
REQ-025 RST asserted mid-frame SHALL abort the frame and discard any buffered byte; no Tx_Done for the aborted frame.
REQ-026 After RST deasserts, SO SHALL stay 1 until a new byte is accepted.

Verification
REQ-027 Single byte 0xA5 accepted from IDLE -> SO = 0,1,0,1,0,0,1,0,1,1 over 10 cycles starting 2 edges after accept, Tx_Done once, Busy 10 cycles.
REQ-028 Bytes 0x00 then 0xFF offered continuously -> second accepted while first is sending, frames contiguous (no idle cycle), SO=1 after the second stop bit, two Tx_Done pulses 10 cycles apart.
REQ-029 Tx_Valid held with buffer full -> Tx_Ready=0 and no accept until START of the buffered frame; Tx_Byte changes mid-frame do not alter SO.
REQ-030 RST pulsed at DATA bit 4 of 0x3C -> SO=1, Busy=0, Tx_Ready=1 asynchronously; no Tx_Done; next byte 0x81 transmits a full correct frame.
REQ-031 STOP_BITS=2, byte 0x5A -> 11-cycle frame, two SO=1 stop cycles, Tx_Done on the edge after the second.
REQ-032 Loopback SO->SI of the sibling receiver, random 256-byte stream -> every received Rx_Byte equals the transmitted byte in order.
